// File: rtl/divider_pkg.sv
// Shared definitions for the constant-time divider: state encoding, default width
// and the iteration-counter sizing helper.
package divider_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } divState;

  // Bits needed to hold the values 0..value, i.e. clog2(value+1).
  function automatic int counterBits(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) <= value) bits++;
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One unsigned restoring-division step, purely combinational. The trial subtraction
// is always evaluated and the result chosen by a mux, so timing never depends on data.
module divider_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] R,
  input  logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] nextR,
  output logic [WIDTH-1:0] nextQ
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;
  logic           negative;

  assign shifted = {R, Q[WIDTH-1]};
  assign trial   = shifted - {1'b0, D};
  // The partial remainder stays below D (or below 2^(WIDTH-1) when D is 0),
  // so the top bit of the WIDTH+1-bit difference is a reliable borrow.
  assign negative = trial[WIDTH];

  assign nextR = negative ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign nextQ = {Q[WIDTH-2:0], ~negative};

endmodule

// File: rtl/divider_constant_time.sv
// Sequential unsigned restoring divider with a fixed WIDTH-cycle start-to-done latency,
// independent of operand values including divide-by-zero.
module divider_constant_time
  import divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divByZero,
  output logic             quotientDone,
  output logic             busy
);

  localparam int CW = counterBits(WIDTH);

  divState          state;
  divState          nextState;
  logic [WIDTH-1:0] regR;
  logic [WIDTH-1:0] regQ;
  logic [WIDTH-1:0] regD;
  logic [WIDTH-1:0] stepR;
  logic [WIDTH-1:0] stepQ;
  logic [CW-1:0]    count;
  logic             accept;
  logic             lastStep;

  assign accept   = start && (state != RUN);
  assign lastStep = (state == RUN) && (count == CW'(1));

  divider_step #(.WIDTH(WIDTH)) stepUnit (
    .R     (regR),
    .Q     (regQ),
    .D     (regD),
    .nextR (stepR),
    .nextQ (stepQ)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process ordering.
      state <= nextState;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns nextState and no latch is inferred.
    nextState = state;
    case (state)
      IDLE, DONE: if (start) nextState = RUN;
      RUN:        if (count == CW'(1)) nextState = DONE;
      default:    nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regR         <= '0;
      regQ         <= '0;
      regD         <= '0;
      count        <= '0;
      quotient     <= '0;
      remainder    <= '0;
      divByZero    <= 1'b0;
      quotientDone <= 1'b0;
      busy         <= 1'b0;
    end else if (accept) begin
      regD         <= divisor;
      regQ         <= dividend;
      regR         <= '0;
      count        <= CW'(WIDTH);
      quotientDone <= 1'b0;
      busy         <= 1'b1;
    end else if (state == RUN) begin
      regR  <= stepR;
      regQ  <= stepQ;
      count <= count - CW'(1);
      if (lastStep) begin
        quotient     <= stepQ;
        remainder    <= stepR;
        divByZero    <= (regD == '0);
        quotientDone <= 1'b1;
        busy         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_divider_constant_time.sv
// Scoreboard bench for divider_constant_time: stimulus pushes expected results,
// a monitor pops and compares on each rising quotientDone.
module tb_divider_constant_time;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         divByZero;
  logic         quotientDone;
  logic         busy;

  logic         startB = 1'b0;
  logic [W-1:0] dividendB = '0;
  logic [W-1:0] divisorB = '0;
  logic [W-1:0] quotientB;
  logic [W-1:0] remainderB;
  logic         divByZeroB;
  logic         quotientDoneB;
  logic         busyB;

  divider_constant_time #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .dividend     (dividend),
    .divisor      (divisor),
    .quotient     (quotient),
    .remainder    (remainder),
    .divByZero    (divByZero),
    .quotientDone (quotientDone),
    .busy         (busy)
  );

  divider_constant_time #(.WIDTH(W)) dutB (
    .clk          (clk),
    .rst          (rst),
    .start        (startB),
    .dividend     (dividendB),
    .divisor      (divisorB),
    .quotient     (quotientB),
    .remainder    (remainderB),
    .divByZero    (divByZeroB),
    .quotientDone (quotientDoneB),
    .busy         (busyB)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           doneCyc;
    string        name;
  } expEntry;

  expEntry sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a falling edge; the operation is captured on the next rising edge.
  task automatic issue(input int a, input int b, input int eq, input int er, input int edz,
                       input string name);
    expEntry e;
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    e.q       = W'(eq);
    e.r       = W'(er);
    e.dz      = (edz != 0);
    e.doneCyc = cyc + 1 + W;
    e.name    = name;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: one scoreboard pop per rising quotientDone.
  initial begin
    logic    prevDone;
    expEntry e;
    prevDone = 1'b0;
    forever begin
      @(negedge clk);
      if (quotientDone && !prevDone) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: quotient=%0d remainder=%0d with no pending request",
                   quotient, remainder);
        end else begin
          e = sb.pop_front();
          check({e.name, "_quotient"},  32'(quotient),  32'(e.q));
          check({e.name, "_remainder"}, 32'(remainder), 32'(e.r));
          check({e.name, "_divByZero"}, 32'(divByZero), 32'(e.dz));
          check({e.name, "_latency"},   32'(cyc),       32'(e.doneCyc));
        end
      end
      prevDone = quotientDone;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic leak;

    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_quotient",     32'(quotient),     32'd0);
    check("rst_remainder",    32'(remainder),    32'd0);
    check("rst_divByZero",    32'(divByZero),    32'd0);
    check("rst_quotientDone", 32'(quotientDone), 32'd0);
    check("rst_busy",         32'(busy),         32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 13 / 4 = 3 r1
    issue(13, 4, 3, 1, 0, "d13_4");
    @(negedge clk);
    start = 1'b0;
    check("d13_4_busy", 32'(busy), 32'd1);
    check("d13_4_doneLow", 32'(quotientDone), 32'd0);
    drain(20);

    // 9 / 0: all-ones quotient, remainder = dividend, same latency
    @(negedge clk);
    issue(9, 0, 15, 9, 1, "d9_0");
    @(negedge clk);
    start = 1'b0;
    drain(20);

    // Paired instances with very different operands must finish together
    @(negedge clk);
    issue(15, 1, 15, 0, 0, "p15_1");
    startB = 1'b1;
    dividendB = W'(0);
    divisorB = W'(7);
    @(negedge clk);
    start = 1'b0;
    startB = 1'b0;
    leak = 1'b0;
    repeat (W + 2) begin
      @(negedge clk);
      if (quotientDone !== quotientDoneB) leak = 1'b1;
    end
    check("pair_timingLeak",  32'(leak),          32'd0);
    check("pairB_done",       32'(quotientDoneB), 32'd1);
    check("pairB_quotient",   32'(quotientB),     32'd0);
    check("pairB_remainder",  32'(remainderB),    32'd0);
    check("pairB_divByZero",  32'(divByZeroB),    32'd0);
    drain(20);

    // Start while busy is ignored; result holds in DONE
    @(negedge clk);
    issue(6, 2, 3, 0, 0, "d6_2");
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    dividend = W'(1);
    divisor = W'(1);
    @(negedge clk);
    start = 1'b0;
    repeat (W + 2) @(negedge clk);
    check("ignore_pending", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    check("hold_quotient",     32'(quotient),     32'd3);
    check("hold_remainder",    32'(remainder),    32'd0);
    check("hold_quotientDone", 32'(quotientDone), 32'd1);

    // Asynchronous reset between edges 2 and 3 of a 14 / 3 operation
    @(negedge clk);
    start = 1'b1;
    dividend = W'(14);
    divisor = W'(3);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    check("midrun_busy", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_quotient",     32'(quotient),     32'd0);
    check("arst_remainder",    32'(remainder),    32'd0);
    check("arst_divByZero",    32'(divByZero),    32'd0);
    check("arst_quotientDone", 32'(quotientDone), 32'd0);
    check("arst_busy",         32'(busy),         32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    issue(14, 3, 4, 2, 0, "d14_3_after_rst");
    @(negedge clk);
    start = 1'b0;
    drain(20);

    // Exhaustive sweep with start held high: a new capture every WIDTH+1 edges
    @(negedge clk);
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        issue(a, b, (b == 0) ? (1 << W) - 1 : a / b, (b == 0) ? a : a % b, (b == 0) ? 1 : 0,
              $sformatf("sweep_%0d_%0d", a, b));
        repeat (W + 1) @(negedge clk);
      end
    end
    start = 1'b0;
    drain(20);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
